instr_fetch_unit: RTL and testbench

//  Fetch-stage initiator for the combinational instruction ROM. Owns the PC, drives the ROM

---
 rtl/ifu_pkg.sv | 6 +
 rtl/ifu_perf_counters.sv | 26 ++
 rtl/instr_fetch_unit.sv | 100 ++++++++++
 tb/tb_instr_fetch_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
   typedef enum logic [1:0] {BOOT, RUN, FAULT} ifu_state_t;
   localparam logic [31:0] INSTR_NOP = 32'hD503201F;
   localparam logic [63:0] PC_STEP = 64'd4;
endpackage

// File: rtl/ifu_perf_counters.sv
// ifu_perf_counters: saturating fetch and bubble counters for the fetch unit
module ifu_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_inc_i,
   input  logic        bubble_inc_i,
   output logic [31:0] fetch_count_o,
   output logic [31:0] bubble_count_o
);
   logic [31:0] fetch_q, fetch_d, bubble_q, bubble_d;
   always_comb begin
      fetch_d  = (fetch_inc_i && fetch_q != '1) ? fetch_q + 32'd1 : fetch_q;
      bubble_d = (bubble_inc_i && bubble_q != '1) ? bubble_q + 32'd1 : bubble_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_q  <= '0;
         bubble_q <= '0;
      end else begin
         fetch_q  <= fetch_d;
         bubble_q <= bubble_d;
      end
   end
   assign fetch_count_o  = fetch_q;
   assign bubble_count_o = bubble_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and IF/ID register feeding decode from a combinational ROM
// Optional IFU_PERF_CNT_EN adds saturating fetch_count/bubble_count outputs.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_address,
   input  logic [31:0] imem_instruction,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_target,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
`ifdef IFU_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count,
`endif
   output logic        fetch_fault
);
   ifu_state_t  state_q, state_d;
   logic [63:0] pc_q, pc_d, if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;
   logic        pc_bad;
   // 65-bit sum so a PC near 2^64 cannot wrap past the bounds check
   assign pc_bad = (pc_q[1:0] != 2'b00) || (({1'b0, pc_q} + 65'd3) >= 65'(IMEM_BYTES));
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (redirect_valid) begin
               pc_d       = redirect_target;
               if_valid_d = 1'b0;
               if_instr_d = INSTR_NOP;
            end else if (!stall) begin
               if (pc_bad) begin
                  state_d    = FAULT;
                  if_valid_d = 1'b0;
                  if_instr_d = INSTR_NOP;
               end else begin
                  pc_d       = pc_q + PC_STEP;
                  if_pc_d    = pc_q;
                  if_instr_d = imem_instruction;
                  if_valid_d = 1'b1;
               end
            end
         end
         FAULT: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         if_pc_q    <= '0;
         if_instr_q <= INSTR_NOP;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
      end
   end
   assign imem_address = pc_q;
   assign if_valid     = if_valid_q;
   assign if_pc        = if_pc_q;
   assign if_instr     = if_instr_q;
   assign fetch_fault  = (state_q == FAULT);
`ifdef IFU_PERF_CNT_EN
   logic fetch_inc, bubble_inc;
   assign fetch_inc  = (state_q == RUN) && !redirect_valid && !stall && !pc_bad;
   assign bubble_inc = (state_q != BOOT) && !if_valid_d;
   ifu_perf_counters u_perf (
      .clk            (clk),
      .reset          (reset),
      .fetch_inc_i    (fetch_inc),
      .bubble_inc_i   (bubble_inc),
      .fetch_count_o  (fetch_count),
      .bubble_count_o (bubble_count)
   );
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus random stimulus against a behavioural fetch model
module tb_instr_fetch_unit;
   localparam int IMEM_BYTES = 1024;
   localparam logic [31:0] NOP = 32'hD503201F;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] imem_address;
   logic [31:0] imem_instruction;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_target = '0;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_count, bubble_count;
`endif
   logic [31:0] mem [IMEM_BYTES/4];
   int vectors = 0;
   int miscompares = 0;
   // model: 0 = just out of reset, 1 = fetching, 2 = faulted
   int          m_mode;
   logic [63:0] m_pc, m_ipc;
   logic [31:0] m_instr;
   logic        m_v;
   int          m_fc, m_bc;

   always #5 clk = ~clk;
   assign imem_instruction = mem[imem_address[9:2]];

   instr_fetch_unit #(.RESET_PC(64'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .if_valid         (if_valid),
      .if_pc            (if_pc),
      .if_instr         (if_instr),
`ifdef IFU_PERF_CNT_EN
      .fetch_count      (fetch_count),
      .bubble_count     (bubble_count),
`endif
      .fetch_fault      (fetch_fault)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".valid"}, 64'(if_valid), 64'(m_v));
      chk({tag, ".if_pc"}, if_pc, m_ipc);
      chk({tag, ".instr"}, 64'(if_instr), 64'(m_instr));
      chk({tag, ".addr"}, imem_address, m_pc);
      chk({tag, ".fault"}, 64'(fetch_fault), 64'(m_mode == 2));
`ifdef IFU_PERF_CNT_EN
      chk({tag, ".fcnt"}, 64'(fetch_count), 64'(m_fc));
      chk({tag, ".bcnt"}, 64'(bubble_count), 64'(m_bc));
`endif
   endtask

   function automatic bit addr_bad(input logic [63:0] a);
      return (a % 4 != 0) || ({1'b0, a} + 65'd3 >= 65'(IMEM_BYTES));
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP; m_v = 1'b0;
      m_fc = 0; m_bc = 0;
   endtask

   // one clock edge with the given controls, then compare everything
   task automatic cyc(input string tag, input logic s, input logic rv, input logic [63:0] rt);
      int prev_mode;
      stall = s; redirect_valid = rv; redirect_target = rt;
      prev_mode = m_mode;
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 2) begin
         if (rv) begin m_pc = rt; m_mode = 1; end
      end else if (rv) begin
         m_pc = rt; m_v = 1'b0; m_instr = NOP;
      end else if (!s) begin
         if (addr_bad(m_pc)) begin
            m_mode = 2; m_v = 1'b0; m_instr = NOP;
         end else begin
            m_v = 1'b1; m_ipc = m_pc; m_instr = mem[m_pc / 4]; m_pc = m_pc + 4;
            if (m_fc != 32'hFFFF_FFFF) m_fc++;
         end
      end
      if (prev_mode != 0 && !m_v && m_bc != 32'hFFFF_FFFF) m_bc++;
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b0;
      model_reset();
      #1 chk_all(tag);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
   endtask

   initial begin
      logic [63:0] t;
      for (int i = 0; i < IMEM_BYTES / 4; i++) mem[i] = $urandom;
      model_reset();
      repeat (3) @(posedge clk);
      #1 chk_all("reset");
      @(negedge clk) reset = 1'b1;
      // boot bubble then sequential fetch
      cyc("boot", 0, 0, 0);
      cyc("seq0", 0, 0, 0);
      cyc("seq4", 0, 0, 0);
      // pc_q is now 8: two stalled edges then release
      cyc("stall1", 1, 0, 0);
      cyc("stall2", 1, 0, 0);
      cyc("unstall", 0, 0, 0);
      // redirect wins over stall
      cyc("redir_stall", 1, 1, 64'h40);
      cyc("after_redir", 0, 0, 0);
      // last word of ROM then run off the end
      cyc("redir_top", 0, 1, 64'h3FC);
      cyc("fetch_top", 0, 0, 0);
      cyc("fault_oob", 0, 0, 0);
      cyc("fault_stall", 1, 0, 0);
      cyc("fault_hold", 0, 0, 0);
      cyc("fault_exit", 0, 1, 64'h10);
      cyc("post_fault", 0, 0, 0);
      cyc("redir_mis", 0, 1, 64'h2);
      cyc("fault_mis", 0, 0, 0);
      cyc("redir_huge", 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc("fault_huge", 0, 0, 0);
      cyc("fault_exit2", 0, 1, 64'h18);
      cyc("run18", 0, 0, 0);
      cyc("run1c", 0, 0, 0);
      // pc_q is 0x20: reset mid-run without a clock edge
      async_reset("async_rst");
      cyc("boot2", 0, 0, 0);
      cyc("seq_after_rst", 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         t = 64'($urandom_range(0, IMEM_BYTES / 4 - 1)) * 4;
         case ($urandom_range(0, 9))
            0: t = t | 64'($urandom_range(1, 3));
            1: t = 64'(IMEM_BYTES) + 64'($urandom_range(0, 64)) * 4;
            2: t = {$urandom, $urandom};
            default: ;
         endcase
         cyc("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), t);
         if (n == 200) begin
            async_reset("rand_rst");
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
